rx_cmd_parser: RTL and testbench

- Sits directly downstream of the UART receiver; consumes its parallel byte and valid strobe, and decodes multi-byte command frames.
- Outputs drive the register file (write/read strobes) and the ALU (operand writes, enable, function, clock-gate enable).
- Guards each frame with error abort and inter-byte timeout, so a broken frame never leaves the system stuck mid-command.

---
 rtl/rx_cmd_parser_pkg.sv | 23 ++
 rtl/rx_cmd_parser_frame_timeout_counter.sv | 30 +++
 rtl/rx_cmd_parser.sv | 127 ++++++++++++
 tb/tb_rx_cmd_parser.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_cmd_parser_pkg.sv
// Shared definitions for the UART command-frame parser: opcodes, FSM states and
// the fixed register-file addresses that receive ALU operands.
package rx_cmd_parser_pkg;

    localparam logic [7:0] OPC_WR      = 8'hAA;
    localparam logic [7:0] OPC_RD      = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_ALU_OPA,
        ST_ALU_OPB,
        ST_ALU_FUN
    } state_t;

endpackage

// File: rtl/rx_cmd_parser_frame_timeout_counter.sv
// Inter-byte watchdog: counts cycles while a frame is open and flags the cycle on
// which the gap since the last byte reaches TIMEOUT_CYCLES.
module rx_cmd_parser_frame_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !enable || expired) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // Flag one cycle early so the abort lands exactly TIMEOUT_CYCLES after the last byte.
    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rx_cmd_parser.sv
// Decodes UART byte streams into register-file and ALU commands, aborting broken
// frames on receiver error, bad opcode or inter-byte timeout.
module rx_cmd_parser
    import rx_cmd_parser_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned FUN_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] Rx_P_Data,
    input  logic                  Rx_Data_valid,
    input  logic                  Rx_frame_error,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic [DATA_WIDTH-1:0] RF_WrData,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  ALU_EN,
    output logic                  ALU_CLK_EN,
    output logic                  Cmd_done,
    output logic                  Frame_abort
);

    state_t state;
    logic   in_frame;
    logic   expired;

    assign in_frame = (state != ST_IDLE);

    rx_cmd_parser_frame_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (CLK),
        .rst_n  (Reset),
        .clear  (Rx_Data_valid),
        .enable (in_frame),
        .expired(expired)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_IDLE;
            RF_Address  <= '0;
            RF_WrData   <= '0;
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            ALU_FUN     <= '0;
            ALU_EN      <= 1'b0;
            ALU_CLK_EN  <= 1'b0;
            Cmd_done    <= 1'b0;
            Frame_abort <= 1'b0;
        end else begin
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            ALU_EN      <= 1'b0;
            Cmd_done    <= 1'b0;
            Frame_abort <= 1'b0;
            // Clock gate follows ALU_FUN residency, which also covers the ALU_EN cycle.
            ALU_CLK_EN  <= (state == ST_ALU_FUN);

            if (in_frame && Rx_frame_error) begin
                Frame_abort <= 1'b1;
                ALU_CLK_EN  <= 1'b0;
                state       <= ST_IDLE;
            end else if (Rx_Data_valid && !Rx_frame_error) begin
                case (state)
                    ST_IDLE: begin
                        case (Rx_P_Data)
                            OPC_WR:      state <= ST_WR_ADDR;
                            OPC_RD:      state <= ST_RD_ADDR;
                            OPC_ALU_OP:  state <= ST_ALU_OPA;
                            OPC_ALU_NOP: begin
                                state      <= ST_ALU_FUN;
                                ALU_CLK_EN <= 1'b1;
                            end
                            default:     Frame_abort <= 1'b1;
                        endcase
                    end
                    ST_WR_ADDR: begin
                        RF_Address <= Rx_P_Data[ADDR_WIDTH-1:0];
                        state      <= ST_WR_DATA;
                    end
                    ST_WR_DATA: begin
                        RF_WrData <= Rx_P_Data;
                        RF_WrEn   <= 1'b1;
                        Cmd_done  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                    ST_RD_ADDR: begin
                        RF_Address <= Rx_P_Data[ADDR_WIDTH-1:0];
                        RF_RdEn    <= 1'b1;
                        Cmd_done   <= 1'b1;
                        state      <= ST_IDLE;
                    end
                    ST_ALU_OPA: begin
                        RF_Address <= ADDR_WIDTH'(OPA_ADDR);
                        RF_WrData  <= Rx_P_Data;
                        RF_WrEn    <= 1'b1;
                        state      <= ST_ALU_OPB;
                    end
                    ST_ALU_OPB: begin
                        RF_Address <= ADDR_WIDTH'(OPB_ADDR);
                        RF_WrData  <= Rx_P_Data;
                        RF_WrEn    <= 1'b1;
                        ALU_CLK_EN <= 1'b1;
                        state      <= ST_ALU_FUN;
                    end
                    ST_ALU_FUN: begin
                        ALU_FUN  <= Rx_P_Data[FUN_WIDTH-1:0];
                        ALU_EN   <= 1'b1;
                        Cmd_done <= 1'b1;
                        state    <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (expired) begin
                Frame_abort <= 1'b1;
                ALU_CLK_EN  <= 1'b0;
                state       <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Scoreboard bench for rx_cmd_parser: a frame-level reference model queues expected
// strobe events, and a negedge monitor checks them as the DUT produces them.
module tb_rx_cmd_parser;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned FW = 4;
    localparam int unsigned TO = 20;

    // strobe vector layout: {wr, rd, alu_en, done, abort}
    localparam logic [4:0] S_WR   = 5'b10000;
    localparam logic [4:0] S_RD   = 5'b01000;
    localparam logic [4:0] S_EN   = 5'b00100;
    localparam logic [4:0] S_DONE = 5'b00010;
    localparam logic [4:0] S_ABT  = 5'b00001;

    logic          CLK = 1'b0;
    logic          Reset = 1'b0;
    logic [DW-1:0] Rx_P_Data = '0;
    logic          Rx_Data_valid = 1'b0;
    logic          Rx_frame_error = 1'b0;
    logic [AW-1:0] RF_Address;
    logic [DW-1:0] RF_WrData;
    logic          RF_WrEn;
    logic          RF_RdEn;
    logic [FW-1:0] ALU_FUN;
    logic          ALU_EN;
    logic          ALU_CLK_EN;
    logic          Cmd_done;
    logic          Frame_abort;

    rx_cmd_parser #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .FUN_WIDTH     (FW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .Rx_P_Data     (Rx_P_Data),
        .Rx_Data_valid (Rx_Data_valid),
        .Rx_frame_error(Rx_frame_error),
        .RF_Address    (RF_Address),
        .RF_WrData     (RF_WrData),
        .RF_WrEn       (RF_WrEn),
        .RF_RdEn       (RF_RdEn),
        .ALU_FUN       (ALU_FUN),
        .ALU_EN        (ALU_EN),
        .ALU_CLK_EN    (ALU_CLK_EN),
        .Cmd_done      (Cmd_done),
        .Frame_abort   (Frame_abort)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed {
        int            cyc;
        logic [4:0]    strb;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [FW-1:0] fun;
    } ev_t;

    ev_t exp_q[$];
    bit  exp_clk_en[int];
    int  checks = 0;
    int  errors = 0;

    // Reference model: kind of open frame (0 none, 1 write, 2 read, 3 alu+ops, 4 alu),
    // payload bytes received so far and idle cycles since the last byte.
    int            m_kind = 0;
    int            m_nbytes = 0;
    int            m_gap = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic [FW-1:0] m_fun = '0;

    task automatic model_reset();
        m_kind = 0; m_nbytes = 0; m_gap = 0;
        m_addr = '0; m_data = '0; m_fun = '0;
        exp_q.delete();
        exp_clk_en.delete();
    endtask

    task automatic model_step(input logic v, input logic [DW-1:0] d, input logic e);
        logic [4:0] s;
        bit         fun_wait;
        ev_t        ev;
        s = '0;
        if (m_kind != 0) begin
            if (e) begin
                s = S_ABT; m_kind = 0;
            end else if (v) begin
                m_nbytes++; m_gap = 0;
                if (m_kind == 1) begin
                    if (m_nbytes == 1) m_addr = d[AW-1:0];
                    else begin m_data = d; s = S_WR | S_DONE; m_kind = 0; end
                end else if (m_kind == 2) begin
                    m_addr = d[AW-1:0]; s = S_RD | S_DONE; m_kind = 0;
                end else if (m_kind == 3 && m_nbytes <= 2) begin
                    m_addr = AW'(m_nbytes - 1); m_data = d; s = S_WR;
                end else begin
                    m_fun = d[FW-1:0]; s = S_EN | S_DONE; m_kind = 0;
                end
            end else begin
                m_gap++;
                if (m_gap >= int'(TO)) begin s = S_ABT; m_kind = 0; end
            end
        end else if (v && !e) begin
            m_nbytes = 0; m_gap = 0;
            case (d)
                8'hAA:   m_kind = 1;
                8'hBB:   m_kind = 2;
                8'hCC:   m_kind = 3;
                8'hDD:   m_kind = 4;
                default: s = S_ABT;
            endcase
        end
        fun_wait = (m_kind == 4 && m_nbytes == 0) || (m_kind == 3 && m_nbytes == 2);
        exp_clk_en[cyc + 1] = fun_wait || (s[2] == 1'b1);
        if (s != '0) begin
            ev.cyc = cyc + 1; ev.strb = s; ev.addr = m_addr; ev.data = m_data; ev.fun = m_fun;
            exp_q.push_back(ev);
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic e);
        @(posedge CLK);
        #1;
        Rx_Data_valid = v; Rx_P_Data = d; Rx_frame_error = e;
        model_step(v, d, e);
    endtask

    task automatic send(input logic [DW-1:0] d, input int gap);
        drive(1'b1, d, 1'b0);
        repeat (gap) drive(1'b0, '0, 1'b0);
    endtask

    task automatic reset_pulse(input int n);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) drive(1'b0, '0, 1'b0);
        @(posedge CLK);
        #1;
        Reset = 1'b0; Rx_Data_valid = 1'b0; Rx_frame_error = 1'b0;
        model_reset();
        repeat (n) @(posedge CLK);
        #1;
        Reset = 1'b1;
    endtask

    always @(negedge CLK) begin
        logic [4:0] got;
        ev_t        ev;
        got = {RF_WrEn, RF_RdEn, ALU_EN, Cmd_done, Frame_abort};
        if (!Reset) begin
            checks++;
            if ({RF_Address, RF_WrData, ALU_FUN, got, ALU_CLK_EN} != '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got addr=%h data=%h fun=%h strb=%b clk_en=%b, required all 0",
                         cyc, RF_Address, RF_WrData, ALU_FUN, got, ALU_CLK_EN);
            end
        end else begin
            if (exp_clk_en.exists(cyc)) begin
                checks++;
                if (ALU_CLK_EN !== exp_clk_en[cyc]) begin
                    errors++;
                    $display("FAIL alu_clk_en cycle %0d: got %b required %b", cyc, ALU_CLK_EN, exp_clk_en[cyc]);
                end
                exp_clk_en.delete(cyc);
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                ev = exp_q.pop_front();
                checks++; errors++;
                $display("FAIL missing_event cycle %0d: got nothing, required strb=%b", ev.cyc, ev.strb);
            end
            if (got != '0) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    errors++;
                    $display("FAIL unexpected_strobe cycle %0d: got strb=%b, required none", cyc, got);
                end else begin
                    ev = exp_q.pop_front();
                    if (got !== ev.strb || RF_Address !== ev.addr || RF_WrData !== ev.data || ALU_FUN !== ev.fun) begin
                        errors++;
                        $display("FAIL event cycle %0d: got strb=%b addr=%h data=%h fun=%h, required strb=%b addr=%h data=%h fun=%h",
                                 cyc, got, RF_Address, RF_WrData, ALU_FUN, ev.strb, ev.addr, ev.data, ev.fun);
                    end
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] b;
        int            g;
        logic          e;
        model_reset();
        repeat (3) @(posedge CLK);
        #1 Reset = 1'b1;

        send(8'hAA, 9); send(8'h05, 9); send(8'h3C, 9);

        send(8'hBB, 0); send(8'h0A, 0);
        send(8'hCC, 0); send(8'h12, 0); send(8'h34, 0); send(8'h03, 3);

        send(8'hAA, 1); send(8'h07, 1);
        drive(1'b1, 8'h55, 1'b1);
        drive(1'b0, '0, 1'b0);
        send(8'hDD, 0); send(8'h08, 3);
        send(8'h5A, 3);

        send(8'hAA, 25);
        send(8'hAA, 19); send(8'h07, 0); send(8'h66, 3);

        send(8'hCC, 1); send(8'h11, 2);
        reset_pulse(3);
        send(8'h22, 2); send(8'h01, 2);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) reset_pulse(2);
            case ($urandom_range(0, 5))
                0: b = 8'hAA;
                1: b = 8'hBB;
                2: b = 8'hCC;
                3: b = 8'hDD;
                default: b = 8'($urandom);
            endcase
            e = ($urandom_range(0, 24) == 0);
            drive(1'b1, b, e);
            g = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 25)) : int'($urandom_range(0, 3));
            for (int k = 0; k < g; k++) drive(1'b0, '0, ($urandom_range(0, 49) == 0));
        end

        repeat (TO + 5) drive(1'b0, '0, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending events, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
